bram_sdp_fifo: RTL and testbench

BRAM_SDP_FIFO -- requirements
Module: bram_sdp_fifo

---
 rtl/bram_sdp_fifo.sv | 70 +++++++
 tb/tb_bram_sdp_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_sdp_fifo.sv
// Single-clock FIFO on a simple-dual-port RAM whose registered read port doubles as the
// output stage (capacity DEPTH+1). Define BRAM_SDP_FIFO_LEVEL_EN to add the `level` output.
module bram_sdp_fifo #(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DWIDTH-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data
`ifdef BRAM_SDP_FIFO_LEVEL_EN
    ,
    output logic [AWIDTH:0]   level
`endif
);
    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH+1)'(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wa;
    logic [AWIDTH-1:0] ra;
    logic [AWIDTH:0]   ram_cnt;
    logic              out_valid;
    logic              push;
    logic              rd;

    // Refusing pushes while full (even with a pop pending) keeps wa != ra whenever
    // both ports are active, so the RAM never sees a same-address read/write.
    assign s_ready = (ram_cnt != FULL_CNT);
    assign push    = s_valid && s_ready;
    assign rd      = (ram_cnt != '0) && (!out_valid || m_ready);
    assign m_valid = out_valid;

    always_ff @(posedge clk) begin
        if (push) mem[wa] <= s_data;
    end

    // Registered read port is the output register; it holds while stalled.
    always_ff @(posedge clk) begin
        if (rd) m_data <= mem[ra];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wa        <= '0;
            ra        <= '0;
            ram_cnt   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) wa <= wa + 1'b1;
            if (rd)   ra <= ra + 1'b1;
            case ({push, rd})
                2'b10:   ram_cnt <= ram_cnt + 1'b1;
                2'b01:   ram_cnt <= ram_cnt - 1'b1;
                default: ;
            endcase
            if (rd)           out_valid <= 1'b1;
            else if (m_ready) out_valid <= 1'b0;
        end
    end

`ifdef BRAM_SDP_FIFO_LEVEL_EN
    assign level = ram_cnt + {{AWIDTH{1'b0}}, out_valid};
`endif

endmodule

// File: tb/tb_bram_sdp_fifo.sv
// Bench for bram_sdp_fifo (AWIDTH=4, DWIDTH=8): queue-based occupancy/visibility model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_bram_sdp_fifo;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
`ifdef BRAM_SDP_FIFO_LEVEL_EN
    logic [AW:0]   level;
`endif

    bram_sdp_fifo #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef BRAM_SDP_FIFO_LEVEL_EN
        , .level(level)
`endif
    );

    always #5 clk = ~clk;

    // Model: every word held, tagged with the edge that accepted it. A word may be
    // shown only once an edge has passed since its acceptance.
    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] out_log[$];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            max_lvl = 0;
    bit            p_mv, p_sr, c_mv;
    ent_t          e;
    logic [DW-1:0] nxt;
    bit            acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            p_mv = 1'b0;
            if (q.size() > 0) p_mv = (q[0].t < cyc);
            p_sr = ((q.size() - int'(p_mv)) != DEPTH);
            if (p_mv && m_ready) void'(q.pop_front());
            cyc++;
            if (s_valid && p_sr) begin
                e.d = s_data;
                e.t = cyc;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            c_mv = 1'b0;
            if (q.size() > 0) c_mv = (q[0].t < cyc);
            chk("m_valid", m_valid, c_mv);
            chk("s_ready", s_ready, (q.size() - int'(c_mv)) != DEPTH);
            if (c_mv) chk("m_data", m_data, q[0].d);
`ifdef BRAM_SDP_FIFO_LEVEL_EN
            chk("level", level, q.size());
            if (int'(level) > max_lvl) max_lvl = int'(level);
`endif
            if (m_valid && m_ready) out_log.push_back(m_data);
        end
    end

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 1);
`ifdef BRAM_SDP_FIFO_LEVEL_EN
        chk("rst_level", level, 0);
`endif
        step(); step();
        rst_n = 1'b1;

        // single word, stalled output
        s_valid = 1'b1; s_data = 8'hA5;
        step();
        s_valid = 1'b0;
        chk("t1_lat0", m_valid, 0);
        step();
        chk("t1_valid", m_valid, 1);
        chk("t1_data", m_data, 8'hA5);
        repeat (5) begin
            step();
            chk("t1_hold_valid", m_valid, 1);
            chk("t1_hold_data", m_data, 8'hA5);
        end
`ifdef BRAM_SDP_FIFO_LEVEL_EN
        chk("t1_level", level, 1);
`endif
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("t1_drained", m_valid, 0);

        // fill to DEPTH+1, then an extra push is refused
        out_log.delete();
        for (int i = 0; i < 17; i++) begin
            chk("t2_ready_pre", s_ready, 1);
            s_valid = 1'b1; s_data = DW'(i);
            step();
        end
        chk("t2_full", s_ready, 0);
`ifdef BRAM_SDP_FIFO_LEVEL_EN
        chk("t2_level", level, 17);
`endif
        s_data = 8'h55;
        step();
        chk("t2_still_full", s_ready, 0);
        chk("t2_head_valid", m_valid, 1);
        chk("t2_head_data", m_data, 8'h00);
`ifdef BRAM_SDP_FIFO_LEVEL_EN
        chk("t2_level_hold", level, 17);
`endif

        // streaming from full across pointer wrap
        nxt = 8'h11;
        m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_data = nxt;
            acc = s_ready;
            step();
            if (acc) nxt = nxt + 8'd1;
        end
        s_valid = 1'b0;
        repeat (20) step();
        chk("t3_count", out_log.size(), 56);
        for (int i = 0; i < out_log.size(); i++) chk("t3_order", out_log[i], DW'(i));

        // continuous push/pop from empty
        out_log.delete();
        max_lvl = 0;
        s_data = 8'h80; s_valid = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (i == 0) chk("t4_lat0", m_valid, 0);
            if (i == 1) begin
                chk("t4_first_valid", m_valid, 1);
                chk("t4_first_data", m_data, 8'h80);
            end
            s_data = s_data + 8'd1;
        end
        s_valid = 1'b0;
        repeat (3) step();
        chk("t4_count", out_log.size(), 100);
        for (int i = 0; i < out_log.size(); i++) chk("t4_order", out_log[i], DW'(8'h80 + i));
`ifdef BRAM_SDP_FIFO_LEVEL_EN
        chk("t4_max_level", max_lvl <= 2, 1);
`endif

        // mid-operation reset
        m_ready = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data = DW'(8'h40 + i);
            step();
        end
        s_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_m_valid", m_valid, 0);
        chk("t5_rst_s_ready", s_ready, 1);
`ifdef BRAM_SDP_FIFO_LEVEL_EN
        chk("t5_rst_level", level, 0);
`endif
        step();
        rst_n = 1'b1;
        s_valid = 1'b1; s_data = 8'h3C;
        step();
        s_valid = 1'b0;
        chk("t5_lat0", m_valid, 0);
        step();
        chk("t5_valid", m_valid, 1);
        chk("t5_data", m_data, 8'h3C);

        // pops on empty are ignored
        m_ready = 1'b1;
        step();
        out_log.delete();
        repeat (10) begin
            step();
            chk("t6_idle", m_valid, 0);
        end
        s_valid = 1'b1; s_data = 8'h11;
        step();
        s_valid = 1'b0;
        repeat (5) step();
        chk("t6_count", out_log.size(), 1);
        if (out_log.size() > 0) chk("t6_data", out_log[0], 8'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
